// File: rtl/spio_hss_multiplexer_rx_link_monitor_pkg.sv
// Shared constants, state encoding and helpers for the HSS receive link monitor.
// Build option: SPIO_HSS_MUX_CC_STRIP_EN removes clock-correction words from the forwarded stream.
package spio_hss_multiplexer_rx_link_monitor_pkg;

    localparam int FRM_BITS = 32;
    localparam int KCH_BITS = 4;

    localparam logic [7:0]          K28_5   = 8'hBC;
    localparam logic [FRM_BITS-1:0] CC_WORD = 32'h1C1C1C1C;

    localparam logic [KCH_BITS-1:0] KCH_NONE = 4'b0000;
    localparam logic [KCH_BITS-1:0] KCH_SYNC = 4'b0001;
    localparam logic [KCH_BITS-1:0] KCH_CC   = 4'b1111;

    typedef enum logic [1:0] {
        ST_LOS    = 2'd0,
        ST_CHECK  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_RESYNC = 2'd3
    } state_t;

    function automatic logic kchr_legal(input logic [KCH_BITS-1:0] k);
        return (k == KCH_NONE) || (k == KCH_SYNC) || (k == KCH_CC);
    endfunction

endpackage

// File: rtl/spio_hss_multiplexer_rx_word_classifier.sv
// Combinational classification of one received word into bad / sync / CC.
// Build option: SPIO_HSS_MUX_CC_STRIP_EN (used by the top, not here).
module spio_hss_multiplexer_rx_word_classifier
    import spio_hss_multiplexer_rx_link_monitor_pkg::*;
(
    input  logic [FRM_BITS-1:0] data,
    input  logic [KCH_BITS-1:0] kchr,
    input  logic [3:0]          derr,
    input  logic                vld,
    output logic                bad,
    output logic                sync,
    output logic                cc
);

    logic k_all;
    logic cc_ok;

    always_comb begin
        k_all = (kchr == KCH_CC);
        cc_ok = k_all && (data == CC_WORD);
        // An all-K word is only legal as the K28.0 clock-correction pattern
        bad   = vld && ((|derr) || !kchr_legal(kchr) || (k_all && !cc_ok));
        sync  = vld && !bad && (kchr == KCH_SYNC) && (data[7:0] == K28_5);
        cc    = vld && !bad && cc_ok;
    end

endmodule

// File: rtl/spio_hss_multiplexer_rx_link_monitor.sv
// Receive-side link monitor: sync FSM, word qualification and error counting.
// Build option: SPIO_HSS_MUX_CC_STRIP_EN drops CC words instead of forwarding them.
module spio_hss_multiplexer_rx_link_monitor
    import spio_hss_multiplexer_rx_link_monitor_pkg::*;
#(
    parameter int SYNC_WORDS    = 16,
    parameter int LOSS_ERRS     = 4,
    parameter int RECOVER_WORDS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FRM_BITS-1:0] rx_data,
    input  logic [KCH_BITS-1:0] rx_kchr,
    input  logic [3:0]          rx_derr,
    input  logic                rx_vld,
    output logic [FRM_BITS-1:0] ihsl_data,
    output logic [KCH_BITS-1:0] ihsl_kchr,
    output logic                ihsl_vld,
    output logic                reg_lsyn,
    output logic                reg_lost,
    output logic [15:0]         reg_errc,
    input  logic                reg_eclr
);

    localparam int GW = $clog2(SYNC_WORDS + 1);
    localparam int BW = $clog2(LOSS_ERRS + 1);
    localparam int RW = $clog2(RECOVER_WORDS + 1);

    state_t        state, state_nxt;
    logic [GW-1:0] good_cnt, good_nxt;
    logic [BW-1:0] bad_cnt, bad_nxt;
    logic [RW-1:0] run_cnt, run_nxt;
    logic          lost_nxt;
    logic          fwd;

    logic w_bad;
    logic w_sync;
    logic w_cc;

    spio_hss_multiplexer_rx_word_classifier u_cls (
        .data (rx_data),
        .kchr (rx_kchr),
        .derr (rx_derr),
        .vld  (rx_vld),
        .bad  (w_bad),
        .sync (w_sync),
        .cc   (w_cc)
    );

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        run_nxt   = run_cnt;
        lost_nxt  = 1'b0;
        if (rx_vld) begin
            unique case (state)
                ST_LOS: begin
                    if (w_sync) begin
                        state_nxt = ST_CHECK;
                        good_nxt  = GW'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_bad) begin
                        state_nxt = ST_LOS;
                        good_nxt  = '0;
                    end else if (w_sync) begin
                        good_nxt = good_cnt + GW'(1);
                        if (good_nxt == GW'(SYNC_WORDS))
                            state_nxt = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_bad) begin
                        state_nxt = ST_RESYNC;
                        bad_nxt   = BW'(1);
                        run_nxt   = '0;
                    end
                end
                ST_RESYNC: begin
                    if (w_bad) begin
                        bad_nxt = bad_cnt + BW'(1);
                        run_nxt = '0;
                        if (bad_nxt == BW'(LOSS_ERRS)) begin
                            state_nxt = ST_LOS;
                            lost_nxt  = 1'b1;
                            bad_nxt   = '0;
                            good_nxt  = '0;
                        end
                    end else begin
                        // CC words count as good here even when stripped
                        run_nxt = run_cnt + RW'(1);
                        if (run_nxt == RW'(RECOVER_WORDS)) begin
                            state_nxt = ST_SYNC;
                            bad_nxt   = '0;
                            run_nxt   = '0;
                        end
                    end
                end
                default: state_nxt = ST_LOS;
            endcase
        end
    end

    always_comb begin
        fwd = rx_vld && !w_bad
            && ((state == ST_SYNC) || (state == ST_RESYNC));
`ifdef SPIO_HSS_MUX_CC_STRIP_EN
        fwd = fwd && !w_cc;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOS;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            run_cnt   <= '0;
            ihsl_data <= '0;
            ihsl_kchr <= '0;
            ihsl_vld  <= 1'b0;
            reg_lsyn  <= 1'b0;
            reg_lost  <= 1'b0;
            reg_errc  <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            run_cnt  <= run_nxt;
            ihsl_vld <= fwd;
            if (fwd) begin
                ihsl_data <= rx_data;
                ihsl_kchr <= rx_kchr;
            end
            reg_lsyn <= (state_nxt == ST_SYNC) || (state_nxt == ST_RESYNC);
            reg_lost <= lost_nxt;
            if (reg_eclr)
                reg_errc <= w_bad ? 16'd1 : 16'd0;
            else if (w_bad && (reg_errc != 16'hFFFF))
                reg_errc <= reg_errc + 16'd1;
        end
    end

endmodule
